// File: rtl/axi_read_slave_lite.sv
// AXI4 read-channel responder: returns bursts whose data is each beat's address.
// Define AXI_RD_SLV_CHECK_EN to flag illegal requests with SLVERR.
package axi_pkg;
  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 32;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
endpackage

module axi_read_slave_lite #(
  parameter int ID_WIDTH   = axi_pkg::ID_WIDTH,
  parameter int ADDR_WIDTH = axi_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready
);
  import axi_pkg::*;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  err;
  } req_t;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t state, state_next;
  req_t   q_mem [2];
  req_t   req_in, head;
  logic   wr_ptr, rd_ptr;
  logic [1:0] q_count;
  logic   push, pop, advance, legal_wrap;

  logic [ADDR_WIDTH-1:0] beat_addr, next_addr, wrap_low, wrap_end;
  logic [ADDR_WIDTH-1:0] bsz, aligned, incr_addr, head_t, head_low;
  logic [7:0]            beat_cnt;
  logic [2:0]            cur_size;
  logic [1:0]            cur_burst;
  logic                  cur_err;

  assign arready = (q_count != 2'd2);
  assign push    = arvalid && arready;
  assign head    = q_mem[rd_ptr];

  // Illegal WRAP lengths and the reserved encoding fall back to INCR addressing.
  always_comb begin
    legal_wrap     = (arlen == 8'd1) || (arlen == 8'd3) || (arlen == 8'd7) || (arlen == 8'd15);
    req_in.id      = arid;
    req_in.addr    = araddr;
    req_in.len     = arlen;
    req_in.size    = arsize;
    req_in.burst   = arburst;
    if (arburst == 2'b11 || (arburst == BURST_WRAP && !legal_wrap))
      req_in.burst = BURST_INCR;
`ifdef AXI_RD_SLV_CHECK_EN
    req_in.err     = (arburst == 2'b11)
                  || ((32'd1 << arsize) > 32'(DATA_WIDTH / 8))
                  || (arburst == BURST_WRAP && !legal_wrap);
`else
    req_in.err     = 1'b0;
`endif
  end

  // NOTE: queue storage carries no reset; validity is tracked by q_count alone.
  always_ff @(posedge aclk) begin
    if (push) q_mem[wr_ptr] <= req_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      q_count <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   q_count <= q_count + 2'd1;
        2'b01:   q_count <= q_count - 2'd1;
        default: q_count <= q_count;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    advance    = 1'b0;
    case (state)
      S_IDLE: begin
        if (q_count != 2'd0) begin
          pop        = 1'b1;
          state_next = S_BURST;
        end
      end
      S_BURST: begin
        if (rready) begin
          if (beat_cnt == 8'd0) begin
            if (q_count != 2'd0) pop = 1'b1;
            else                 state_next = S_IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bsz       = ADDR_WIDTH'(1) << cur_size;
    aligned   = beat_addr & ~(bsz - ADDR_WIDTH'(1));
    incr_addr = aligned + bsz;
    head_t    = (ADDR_WIDTH'(head.len) + ADDR_WIDTH'(1)) << head.size;
    head_low  = head.addr & ~(head_t - ADDR_WIDTH'(1));
    case (cur_burst)
      BURST_FIXED: next_addr = beat_addr;
      BURST_WRAP:  next_addr = (incr_addr == wrap_end) ? wrap_low : incr_addr;
      default:     next_addr = incr_addr;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_addr <= '0;
      beat_cnt  <= 8'd0;
      rid       <= '0;
      cur_size  <= 3'd0;
      cur_burst <= BURST_FIXED;
      cur_err   <= 1'b0;
      wrap_low  <= '0;
      wrap_end  <= '0;
    end else if (pop) begin
      beat_addr <= head.addr;
      beat_cnt  <= head.len;
      rid       <= head.id;
      cur_size  <= head.size;
      cur_burst <= head.burst;
      cur_err   <= head.err;
      wrap_low  <= head_low;
      wrap_end  <= head_low + head_t;
    end else if (advance) begin
      beat_addr <= next_addr;
      beat_cnt  <= beat_cnt - 8'd1;
    end
  end

  assign rvalid = (state == S_BURST);
  assign rlast  = rvalid && (beat_cnt == 8'd0);
  assign rresp  = cur_err ? 2'b10 : 2'b00;
  assign rdata  = cur_err ? '0 : DATA_WIDTH'(beat_addr);

endmodule

// File: tb/tb_axi_read_slave_lite.sv
// Directed bench for axi_read_slave_lite: burst vector table plus queue,
// backpressure and mid-burst reset sequences.
module tb_axi_read_slave_lite;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int n_checks = 0;
  int n_pass   = 0;

  axi_read_slave_lite dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [1:0]       resp;
    logic [7:0][31:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [1:0] resp,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic [31:0] d4, input logic [31:0] d5,
                              input logic [31:0] d6, input logic [31:0] d7);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.resp = resp;
    v.exp[0] = d0; v.exp[1] = d1; v.exp[2] = d2; v.exp[3] = d3;
    v.exp[4] = d4; v.exp[5] = d5; v.exp[6] = d6; v.exp[7] = d7;
    return v;
  endfunction

  // Drives one AR and returns #1 after the accepting edge.
  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t;
    @(negedge aclk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 20) begin
      @(negedge aclk);
      t++;
    end
    if (t == 20) check("ar_timeout", 0, 1);
    @(posedge aclk);
    #1 arvalid = 1'b0;
  endtask

  task automatic run_vector(input vec_t v);
    rready = 1'b1;
    send_ar(v.id, v.addr, v.len, v.size, v.burst);
    @(negedge aclk);
    check("latency_rvalid_low", rvalid, 0);
    for (int b = 0; b <= int'(v.len); b++) begin
      @(negedge aclk);
      check("beat_rvalid", rvalid, 1);
      check("beat_rdata", rdata, v.exp[b]);
      check("beat_rid", rid, v.id);
      check("beat_rresp", rresp, v.resp);
      check("beat_rlast", rlast, (b == int'(v.len)));
    end
    @(negedge aclk);
    check("burst_end_rvalid", rvalid, 0);
  endtask

  // Queue-drain expectations: {id, data, rlast, arready}.
  logic [3:0]  q_id  [6] = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3};
  logic [31:0] q_dat [6] = '{32'h300, 32'h304, 32'h400, 32'h500, 32'h504, 32'h508};
  logic        q_lst [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        q_rdy [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int beat, cyc;
    logic tog;

    vecs[0] = mk(4'h1, 32'h100, 8'd3, 3'd2, 2'b01, 2'b00,
                 32'h100, 32'h104, 32'h108, 32'h10C, 0, 0, 0, 0);
    vecs[1] = mk(4'h2, 32'h38, 8'd3, 3'd2, 2'b10, 2'b00,
                 32'h38, 32'h3C, 32'h30, 32'h34, 0, 0, 0, 0);
    vecs[2] = mk(4'h3, 32'h20, 8'd2, 3'd2, 2'b00, 2'b00,
                 32'h20, 32'h20, 32'h20, 0, 0, 0, 0, 0);
    vecs[3] = mk(4'h4, 32'h41, 8'd1, 3'd2, 2'b01, 2'b00,
                 32'h41, 32'h44, 0, 0, 0, 0, 0, 0);
    vecs[6] = mk(4'h7, 32'h0E, 8'd7, 3'd1, 2'b10, 2'b00,
                 32'h0E, 32'h00, 32'h02, 32'h04, 32'h06, 32'h08, 32'h0A, 32'h0C);
`ifdef AXI_RD_SLV_CHECK_EN
    vecs[4] = mk(4'h5, 32'h80, 8'd1, 3'd2, 2'b11, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[5] = mk(4'h6, 32'h10, 8'd2, 3'd2, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
`else
    vecs[4] = mk(4'h5, 32'h80, 8'd1, 3'd2, 2'b11, 2'b00,
                 32'h80, 32'h84, 0, 0, 0, 0, 0, 0);
    vecs[5] = mk(4'h6, 32'h10, 8'd2, 3'd2, 2'b10, 2'b00,
                 32'h10, 32'h14, 32'h18, 0, 0, 0, 0, 0);
`endif

    aresetn = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0;
    arburst = '0; arvalid = 1'b0; rready = 1'b0;
    #1;
    check("rst_arready", arready, 1);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rid", rid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;

    for (int i = 0; i < 7; i++) run_vector(vecs[i]);

    // Three back-to-back requests while the master stalls.
    rready = 1'b0;
    @(negedge aclk);
    arid = 4'd1; araddr = 32'h300; arlen = 8'd1; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    check("q_ar1_ready", arready, 1);
    @(posedge aclk);
    #1 arid = 4'd2; araddr = 32'h400; arlen = 8'd0;
    @(negedge aclk);
    check("q_ar2_ready", arready, 1);
    @(posedge aclk);
    #1 arid = 4'd3; araddr = 32'h500; arlen = 8'd2;
    @(negedge aclk);
    check("q_ar3_ready", arready, 1);
    @(posedge aclk);
    #1 arvalid = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      check("q_full_arready", arready, 0);
      check("q_stall_rvalid", rvalid, 1);
      check("q_stall_rid", rid, 1);
    end
    rready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("q_rvalid", rvalid, 1);
      check("q_rid", rid, q_id[k]);
      check("q_rdata", rdata, q_dat[k]);
      check("q_rlast", rlast, q_lst[k]);
      check("q_arready", arready, q_rdy[k]);
      @(negedge aclk);
    end
    check("q_drained_rvalid", rvalid, 0);

    // Alternating backpressure on an 8-beat burst.
    rready = 1'b0;
    send_ar(4'd5, 32'h200, 8'd7, 3'd2, 2'b01);
    cyc = 0;
    while (!rvalid && cyc < 10) begin
      @(negedge aclk);
      cyc++;
    end
    beat = 0; cyc = 0; tog = 1'b1;
    while (beat < 8 && cyc < 40) begin
      check("bp_rvalid", rvalid, 1);
      check("bp_rdata", rdata, 32'h200 + 32'(4 * beat));
      check("bp_rlast", rlast, (beat == 7));
      check("bp_rid", rid, 4'd5);
      rready = tog;
      if (tog) beat++;
      tog = ~tog;
      @(negedge aclk);
      cyc++;
    end
    check("bp_beats", beat, 8);
    check("bp_end_rvalid", rvalid, 0);

    // Reset in the middle of a burst with another request queued.
    rready = 1'b1;
    send_ar(4'd6, 32'h600, 8'd7, 3'd2, 2'b01);
    send_ar(4'd7, 32'h700, 8'd3, 3'd2, 2'b01);
    @(negedge aclk);
    check("mid_rvalid_before", rvalid, 1);
    aresetn = 1'b0;
    #1;
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_arready", arready, 1);
    check("mid_rst_rlast", rlast, 0);
    check("mid_rst_rid", rid, 0);
    check("mid_rst_rdata", rdata, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (4) begin
      @(negedge aclk);
      check("post_rst_rvalid", rvalid, 0);
      check("post_rst_arready", arready, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
